note_recorder: RTL and testbench

Captures player button presses on two lanes, one step per scroll tick, and assembles them into two 32-bit note patterns for the scroller's load path (mode 3). It is the writer for the scrolling note display: the scroller shifts patterns out MSB-first toward the display window, and this block builds those patterns MSB-first from live input. It sits between the debounced lane buttons, the shared scroll strobe, and the scroller's `notes1`/`notes2` inputs.

---
 rtl/note_recorder.sv | 154 +++++++++++++++
 tb/tb_note_recorder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
// ============================================================================
// note_recorder : records two lanes of button presses, one bit per scroll step,
//                 into left-justified 32-bit note patterns for the scroller.
// Revision 1.0
// ============================================================================
`default_nettype none

module note_recorder #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        ack,
  input  logic        scroll,
  input  logic        btn1,
  input  logic        btn2,
  output logic [31:0] notes1,
  output logic [31:0] notes2,
  output logic        busy,
  output logic        done,
  output logic [5:0]  step,
  output logic [13:0] preview
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ARMED  = 2'd1;
  localparam logic [1:0]  S_RECORD = 2'd2;
  localparam logic [1:0]  S_DONE   = 2'd3;

  localparam logic [5:0]  C_STEPS  = 6'(STEPS);
  localparam int unsigned C_SHIFT  = 32 - STEPS;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [31:0] r_sr1;
  logic [31:0] r_sr2;
  logic        r_sticky1;
  logic        r_sticky2;
  logic [5:0]  r_step;
  logic [31:0] r_notes1;
  logic [31:0] r_notes2;

  logic        w_abort;
  logic        w_start;
  logic        w_last;
  logic        w_hit1;
  logic        w_hit2;
  logic [31:0] w_sr1_next;
  logic [31:0] w_sr2_next;

  assign w_abort    = abort && (r_state != S_IDLE);
  assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_state == S_RECORD) && scroll && ((r_step + 6'd1) == C_STEPS);
  // A press landing on the scroll cycle itself still belongs to the closing window.
  assign w_hit1     = r_sticky1 | btn1;
  assign w_hit2     = r_sticky2 | btn2;
  assign w_sr1_next = {r_sr1[30:0], w_hit1};
  assign w_sr2_next = {r_sr2[30:0], w_hit2};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_ARMED;
      end
      S_ARMED: begin
        if (abort)       w_state_next = S_IDLE;
        else if (scroll) w_state_next = S_RECORD;
      end
      S_RECORD: begin
        if (abort)       w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (abort)       w_state_next = S_IDLE;
        else if (start)  w_state_next = S_ARMED;
        else if (ack)    w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_ARMED:  busy = 1'b1;
      S_RECORD: busy = 1'b1;
      S_DONE:   done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_abort || w_start) begin
      r_sr1     <= '0;
      r_sr2     <= '0;
      r_sticky1 <= 1'b0;
      r_sticky2 <= 1'b0;
      r_step    <= '0;
      r_notes1  <= '0;
      r_notes2  <= '0;
    end else begin
      case (r_state)
        S_ARMED: begin
          r_sticky1 <= 1'b0;
          r_sticky2 <= 1'b0;
        end
        S_RECORD: begin
          if (scroll) begin
            r_sr1     <= w_sr1_next;
            r_sr2     <= w_sr2_next;
            r_sticky1 <= 1'b0;
            r_sticky2 <= 1'b0;
            r_step    <= r_step + 6'd1;
            // Left-justify so the first recorded step sits in bit 31.
            if (w_last) begin
              r_notes1 <= w_sr1_next << C_SHIFT;
              r_notes2 <= w_sr2_next << C_SHIFT;
            end
          end else begin
            r_sticky1 <= w_hit1;
            r_sticky2 <= w_hit2;
          end
        end
        default: begin
          r_sticky1 <= r_sticky1;
          r_sticky2 <= r_sticky2;
        end
      endcase
    end
  end

  assign notes1  = r_notes1;
  assign notes2  = r_notes2;
  assign step    = r_step;
  assign preview = {r_sr2[6:0], r_sr1[6:0]};

endmodule

`default_nettype wire

// File: tb/tb_note_recorder.sv
// Testbench for note_recorder: table vectors, directed takes and a random run
// against a step-list reference model, on STEPS=32 and STEPS=8 instances.
`default_nettype none

module tb_note_recorder;

  logic clk = 1'b0;
  logic rst, start, abort, ack, scroll, btn1, btn2;
  logic [31:0] n1_a, n2_a, n1_b, n2_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [5:0]  step_a, step_b;
  logic [13:0] prev_a, prev_b;

  always #5 clk = ~clk;

  note_recorder #(.STEPS(32)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ack(ack), .scroll(scroll),
    .btn1(btn1), .btn2(btn2), .notes1(n1_a), .notes2(n2_a), .busy(busy_a),
    .done(done_a), .step(step_a), .preview(prev_a)
  );

  note_recorder #(.STEPS(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ack(ack), .scroll(scroll),
    .btn1(btn1), .btn2(btn2), .notes1(n1_b), .notes2(n2_b), .busy(busy_b),
    .done(done_b), .step(step_b), .preview(prev_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 armed, 2 record, 3 done; m_r* holds step i at index i.
  int          m_mode [2];
  int          m_cnt  [2];
  logic [31:0] m_r1   [2];
  logic [31:0] m_r2   [2];
  logic        m_w1   [2];
  logic        m_w2   [2];
  logic [31:0] m_n1   [2];
  logic [31:0] m_n2   [2];

  function automatic int steps_of(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int k);
    m_cnt[k] = 0;
    m_r1[k]  = '0;
    m_r2[k]  = '0;
    m_w1[k]  = 1'b0;
    m_w2[k]  = 1'b0;
    m_n1[k]  = '0;
    m_n2[k]  = '0;
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_clear(k);
        m_mode[k] = 0;
      end else if (abort && m_mode[k] != 0) begin
        model_clear(k);
        m_mode[k] = 0;
      end else if (start && (m_mode[k] == 0 || m_mode[k] == 3)) begin
        model_clear(k);
        m_mode[k] = 1;
      end else begin
        case (m_mode[k])
          1: if (scroll) begin
            m_mode[k] = 2;
            m_w1[k] = 1'b0;
            m_w2[k] = 1'b0;
          end
          2: begin
            if (scroll) begin
              m_r1[k][m_cnt[k]] = m_w1[k] | btn1;
              m_r2[k][m_cnt[k]] = m_w2[k] | btn2;
              m_cnt[k]++;
              m_w1[k] = 1'b0;
              m_w2[k] = 1'b0;
              if (m_cnt[k] == steps_of(k)) begin
                m_mode[k] = 3;
                m_n1[k] = '0;
                m_n2[k] = '0;
                for (int i = 0; i < steps_of(k); i++) begin
                  m_n1[k][31-i] = m_r1[k][i];
                  m_n2[k][31-i] = m_r2[k][i];
                end
              end
            end else begin
              m_w1[k] = m_w1[k] | btn1;
              m_w2[k] = m_w2[k] | btn2;
            end
          end
          3: if (ack) m_mode[k] = 0;
          default: m_mode[k] = 0;
        endcase
      end
    end
  endtask

  task automatic compare_model();
    logic [13:0] p;
    for (int k = 0; k < 2; k++) begin
      p = '0;
      for (int j = 0; j < 7; j++) begin
        if (m_cnt[k] - 1 - j >= 0) begin
          p[j]     = m_r1[k][m_cnt[k]-1-j];
          p[7 + j] = m_r2[k][m_cnt[k]-1-j];
        end
      end
      if (k == 0) begin
        check("a.notes1", n1_a, m_n1[0]);
        check("a.notes2", n2_a, m_n2[0]);
        check("a.busy", 32'(busy_a), 32'(m_mode[0] == 1 || m_mode[0] == 2));
        check("a.done", 32'(done_a), 32'(m_mode[0] == 3));
        check("a.step", 32'(step_a), 32'(m_cnt[0]));
        check("a.preview", 32'(prev_a), 32'(p));
      end else begin
        check("b.notes1", n1_b, m_n1[1]);
        check("b.notes2", n2_b, m_n2[1]);
        check("b.busy", 32'(busy_b), 32'(m_mode[1] == 1 || m_mode[1] == 2));
        check("b.done", 32'(done_b), 32'(m_mode[1] == 3));
        check("b.step", 32'(step_b), 32'(m_cnt[1]));
        check("b.preview", 32'(prev_b), 32'(p));
      end
    end
  endtask

  task automatic tick(input logic r, s, a, k, sc, b1, b2);
    @(negedge clk);
    rst = r; start = s; abort = a; ack = k; scroll = sc; btn1 = b1; btn2 = b2;
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic        r, s, a, k, sc, b1, b2;
    logic        busy, done;
    logic [5:0]  step;
    logic [13:0] prev;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [7:0] pat;
    rst = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0; scroll = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      m_mode[k] = 0;
    end

    //            r  s  a  k  sc b1 b2  busy done step   prev
    tbl[0]  = '{1, 1, 0, 0, 1, 1, 1,  0, 0, 6'd0, 14'h0000};
    tbl[1]  = '{1, 0, 1, 1, 0, 1, 0,  0, 0, 6'd0, 14'h0000};
    tbl[2]  = '{0, 0, 0, 0, 1, 1, 1,  0, 0, 6'd0, 14'h0000};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 0,  0, 0, 6'd0, 14'h0000};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 0,  1, 0, 6'd0, 14'h0000};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1,  1, 0, 6'd0, 14'h0000};
    tbl[6]  = '{0, 0, 0, 0, 1, 0, 0,  1, 0, 6'd0, 14'h0000};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 6'd0, 14'h0000};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 0,  1, 0, 6'd0, 14'h0000};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 6'd0, 14'h0000};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 0,  1, 0, 6'd1, 14'h0001};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 6'd1, 14'h0001};
    tbl[12] = '{0, 0, 0, 0, 1, 1, 0,  1, 0, 6'd2, 14'h0003};
    tbl[13] = '{0, 1, 0, 0, 0, 0, 0,  1, 0, 6'd2, 14'h0003};
    tbl[14] = '{0, 0, 1, 0, 1, 0, 0,  0, 0, 6'd0, 14'h0000};
    tbl[15] = '{0, 0, 0, 0, 1, 1, 0,  0, 0, 6'd0, 14'h0000};

    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].k, tbl[i].sc, tbl[i].b1, tbl[i].b2);
      check("tbl.busy", 32'(busy_a), 32'(tbl[i].busy));
      check("tbl.done", 32'(done_a), 32'(tbl[i].done));
      check("tbl.step", 32'(step_a), 32'(tbl[i].step));
      check("tbl.preview", 32'(prev_a), 32'(tbl[i].prev));
      check("tbl.notes1", n1_a, 32'h0);
    end

    // Full 32-step take, scroll every 4 cycles
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    for (int s = 0; s < 32; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick(0, 0, 0, 0, c == 3, (s % 2) == 0, 1);
        if (s == 31 && c == 2) check("full.done_early", 32'(done_a), 32'h0);
      end
    end
    check("full.done", 32'(done_a), 32'h1);
    check("full.busy", 32'(busy_a), 32'h0);
    check("full.notes1", n1_a, 32'hAAAAAAAA);
    check("full.notes2", n2_a, 32'hFFFFFFFF);
    check("full.step", 32'(step_a), 32'd32);
    tick(0, 0, 0, 1, 0, 0, 0);
    check("ack.done", 32'(done_a), 32'h0);
    check("ack.busy", 32'(busy_a), 32'h0);
    check("ack.notes1", n1_a, 32'hAAAAAAAA);
    check("ack.step", 32'(step_a), 32'd32);

    // Back-to-back scrolls, then start+ack together in DONE
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    for (int s = 0; s < 32; s++) tick(0, 0, 0, 0, 1, 1'($urandom), 1'($urandom));
    check("b2b.done", 32'(done_a), 32'h1);
    tick(0, 1, 0, 1, 0, 0, 0);
    check("startack.busy", 32'(busy_a), 32'h1);
    check("startack.notes1", n1_a, 32'h0);
    check("startack.step", 32'(step_a), 32'h0);

    // Abort after 10 recorded steps
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    for (int s = 0; s < 10; s++) tick(0, 0, 0, 0, 1, 1'($urandom), 1);
    check("abort.step_before", 32'(step_a), 32'd10);
    tick(0, 0, 1, 0, 0, 0, 0);
    check("abort.busy", 32'(busy_a), 32'h0);
    check("abort.step", 32'(step_a), 32'h0);
    check("abort.preview", 32'(prev_a), 32'h0);
    check("abort.notes2", n2_a, 32'h0);
    for (int s = 0; s < 3; s++) tick(0, 0, 0, 0, 1, 1, 1);
    check("abort.idle_step", 32'(step_a), 32'h0);

    // STEPS=8 take
    pat = 8'b11001100;
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("s8.done_early", 32'(done_b), 32'h0);
      tick(0, 0, 0, 0, 1, pat[7-i], 0);
    end
    check("s8.done", 32'(done_b), 32'h1);
    check("s8.notes1", n1_b, 32'hCC000000);
    check("s8.step", 32'(step_b), 32'd8);

    // Random run against the model
    for (int i = 0; i < 2000; i++) begin
      tick(($urandom % 400) == 0, ($urandom % 30) == 0, ($urandom % 150) == 0,
           ($urandom % 8) == 0, ($urandom % 3) == 0, 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
